wb_pipe_stage: RTL and testbench

WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

---
 rtl/wb_pipe_stage.sv | 137 +++++++++++++
 tb/tb_wb_pipe_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_stage.sv
// wb_pipe_stage -- write-back pipeline stage with valid/ready handshake.
//
// Holds one beat in the default build. With WB_PIPE_SKID_EN defined it
// holds up to two beats (main + skid entry), and in_ready comes straight
// from a flop so there is no combinational path from out_ready.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   flush            synchronous discard of every held beat (and any beat
//                    accepted in the same cycle)
//   in_valid/ready   upstream handshake
//   in_*             upstream payload (wb_en, mem_read, alu_res, mem_data, dest)
//   out_valid/ready  downstream handshake
//   out_*            held payload; out_wb_en is gated by out_valid
//   out_wb_value     out_mem_data when out_mem_read, else out_alu_res
//   out_count        number of beats held (0..2)
module wb_pipe_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wb_en,
  input  logic                  in_mem_read,
  input  logic [DATA_W-1:0]     in_alu_res,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [REG_ADDR_W-1:0] in_dest,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_wb_en,
  output logic                  out_mem_read,
  output logic [DATA_W-1:0]     out_alu_res,
  output logic [DATA_W-1:0]     out_mem_data,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic [DATA_W-1:0]     out_wb_value,
  output logic [1:0]            out_count
);

  localparam int PAY_W = 2 + 2 * DATA_W + REG_ADDR_W;

  logic [PAY_W-1:0] in_pay;
  logic             main_valid_q, main_valid_d;
  logic [PAY_W-1:0] main_pay_q, main_pay_d;
  logic             accept;
  logic             retire;
  logic             pay_wb_en;

  assign in_pay = {in_wb_en, in_mem_read, in_alu_res, in_mem_data, in_dest};
  assign accept = in_valid & in_ready;
  assign retire = main_valid_q & out_ready;

`ifdef WB_PIPE_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [PAY_W-1:0] skid_pay_q, skid_pay_d;

  // Skid entry free means a beat can always be absorbed, even if the main
  // entry stalls this very cycle.
  assign in_ready  = ~skid_valid_q;
  assign out_count = {main_valid_q & skid_valid_q, main_valid_q ^ skid_valid_q};

  always_comb begin
    main_valid_d = main_valid_q;
    main_pay_d   = main_pay_q;
    skid_valid_d = skid_valid_q;
    skid_pay_d   = skid_pay_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      // Skid is never occupied while main is empty.
      if (accept) begin
        main_valid_d = 1'b1;
        main_pay_d   = in_pay;
      end
    end else if (retire) begin
      if (skid_valid_q) begin
        // in_ready is low while skid is full, so no accept can coincide.
        main_pay_d   = skid_pay_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_pay_d = in_pay;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_pay_d   = in_pay;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_pay_q   <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_pay_q   <= skid_pay_d;
    end
  end
`else
  assign in_ready  = ~main_valid_q | out_ready;
  assign out_count = {1'b0, main_valid_q};

  always_comb begin
    main_valid_d = main_valid_q;
    main_pay_d   = main_pay_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_pay_d   = in_pay;
    end else if (retire) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_pay_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_pay_q   <= main_pay_d;
    end
  end

  assign {pay_wb_en, out_mem_read, out_alu_res, out_mem_data, out_dest} = main_pay_q;
  assign out_valid    = main_valid_q;
  // A bubble must never write the register file.
  assign out_wb_en    = main_valid_q & pay_wb_en;
  assign out_wb_value = out_mem_read ? out_mem_data : out_alu_res;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed testbench for wb_pipe_stage. Inputs are driven and outputs
// sampled on the falling clock edge, half a cycle away from the active edge.
module tb_wb_pipe_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wb_en = 1'b0;
  logic        in_mem_read = 1'b0;
  logic [31:0] in_alu_res = '0;
  logic [31:0] in_mem_data = '0;
  logic [3:0]  in_dest = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_wb_en;
  logic        out_mem_read;
  logic [31:0] out_alu_res;
  logic [31:0] out_mem_data;
  logic [3:0]  out_dest;
  logic [31:0] out_wb_value;
  logic [1:0]  out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_pipe_stage #(.DATA_W(32), .REG_ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_en(in_wb_en), .in_mem_read(in_mem_read),
    .in_alu_res(in_alu_res), .in_mem_data(in_mem_data), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wb_en(out_wb_en), .out_mem_read(out_mem_read),
    .out_alu_res(out_alu_res), .out_mem_data(out_mem_data), .out_dest(out_dest),
    .out_wb_value(out_wb_value), .out_count(out_count)
  );

  // Stimulus-only helper: present a beat on the upstream port.
  task automatic set_beat(input logic wb, input logic mr, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [3:0] dst);
    in_valid = 1'b1; in_wb_en = wb; in_mem_read = mr;
    in_alu_res = alu; in_mem_data = mem; in_dest = dst;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
    checks++; if (out_count !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", out_count); end
    checks++; if (out_wb_en !== 1'b0) begin errors++; $display("FAIL rst_wb_en: got %0b want 0", out_wb_en); end
    checks++; if (out_wb_value !== 32'h0) begin errors++; $display("FAIL rst_wb_value: got %h want 0", out_wb_value); end
    checks++; if (out_dest !== 4'h0) begin errors++; $display("FAIL rst_dest: got %h want 0", out_dest); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    $display("txn reset released");
  endtask

  task automatic test_alu_beat();
    out_ready = 1'b1;
    set_beat(1'b1, 1'b0, 32'h0000_1234, 32'h0000_5555, 4'd3);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %0b want 1", out_valid); end
    checks++; if (out_wb_value !== 32'h0000_1234) begin errors++; $display("FAIL alu_wb_value: got %h want 00001234", out_wb_value); end
    checks++; if (out_dest !== 4'd3) begin errors++; $display("FAIL alu_dest: got %0d want 3", out_dest); end
    checks++; if (out_wb_en !== 1'b1) begin errors++; $display("FAIL alu_wb_en: got %0b want 1", out_wb_en); end
    checks++; if (out_count !== 2'd1) begin errors++; $display("FAIL alu_count: got %0d want 1", out_count); end
    $display("txn alu beat wb_value=%h dest=%0d", out_wb_value, out_dest);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alu_retired: got %0b want 0", out_valid); end
    checks++; if (out_wb_en !== 1'b0) begin errors++; $display("FAIL bubble_wb_en: got %0b want 0", out_wb_en); end
  endtask

  task automatic test_mem_beat();
    out_ready = 1'b1;
    set_beat(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'd5);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_wb_value !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mem_wb_value: got %h want deadbeef", out_wb_value); end
    checks++; if (out_alu_res !== 32'h0000_0010) begin errors++; $display("FAIL mem_alu_res: got %h want 00000010", out_alu_res); end
    checks++; if (out_mem_read !== 1'b1) begin errors++; $display("FAIL mem_mem_read: got %0b want 1", out_mem_read); end
    $display("txn mem beat wb_value=%h", out_wb_value);
    @(negedge clk);
  endtask

`ifdef WB_PIPE_SKID_EN
  task automatic test_skid_stall();
    out_ready = 1'b0;
    set_beat(1'b1, 1'b0, 32'hA, 32'h0, 4'd1);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_b: got %0b want 1", in_ready); end
    set_beat(1'b1, 1'b0, 32'hB, 32'h0, 4'd2);
    @(negedge clk);
    set_beat(1'b1, 1'b0, 32'hC, 32'h0, 4'd3);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_c: got %0b want 0", in_ready); end
    checks++; if (out_count !== 2'd2) begin errors++; $display("FAIL skid_count: got %0d want 2", out_count); end
    @(negedge clk);
    checks++; if (out_alu_res !== 32'hA) begin errors++; $display("FAIL skid_stable: got %h want a", out_alu_res); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_hold: got %0b want 0", in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_alu_res !== 32'hB || out_valid !== 1'b1) begin errors++; $display("FAIL skid_order_b: got %h v=%0b want b", out_alu_res, out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_free: got %0b want 1", in_ready); end
    $display("txn skid retire A, now B");
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_alu_res !== 32'hC || out_valid !== 1'b1) begin errors++; $display("FAIL skid_order_c: got %h v=%0b want c", out_alu_res, out_valid); end
    $display("txn skid retire B, now C");
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_count !== 2'd0) begin errors++; $display("FAIL skid_drained: got v=%0b cnt=%0d want 0/0", out_valid, out_count); end
  endtask
`else
  task automatic test_single_stall();
    out_ready = 1'b0;
    set_beat(1'b1, 1'b0, 32'hA, 32'h0, 4'd1);
    @(negedge clk);
    set_beat(1'b1, 1'b0, 32'hB, 32'h0, 4'd2);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL one_ready_stall: got %0b want 0", in_ready); end
    checks++; if (out_count !== 2'd1) begin errors++; $display("FAIL one_count: got %0d want 1", out_count); end
    @(negedge clk);
    checks++; if (out_alu_res !== 32'hA || out_count !== 2'd1) begin errors++; $display("FAIL one_stable: got %h cnt=%0d want a/1", out_alu_res, out_count); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL one_ready_comb: got %0b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_alu_res !== 32'hB || out_valid !== 1'b1) begin errors++; $display("FAIL one_order_b: got %h v=%0b want b", out_alu_res, out_valid); end
    $display("txn single retire A, now B");
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL one_drained: got %0b want 0", out_valid); end
  endtask
`endif

  task automatic test_flush();
    // Load the stage as full as it goes, then flush with a beat on offer.
    out_ready = 1'b0;
    set_beat(1'b1, 1'b0, 32'hF1, 32'h0, 4'd7);
    @(negedge clk);
    set_beat(1'b1, 1'b0, 32'hF2, 32'h0, 4'd8);
    @(negedge clk);
    set_beat(1'b1, 1'b0, 32'hF3, 32'h0, 4'd9);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
    checks++; if (out_count !== 2'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", out_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %0b want 1", in_ready); end
    checks++; if (out_wb_en !== 1'b0) begin errors++; $display("FAIL flush_wb_en: got %0b want 0", out_wb_en); end
    // Empty stage, accept and flush coincide: the beat must be dropped.
    set_beat(1'b1, 1'b0, 32'hF4, 32'h0, 4'd10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_accept_drop: got %0b want 0", out_valid); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost: cycle %0d got valid=%0b alu=%h want 0", k, out_valid, out_alu_res); end
    end
    $display("txn flush done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_val;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        exp_val = ((i - 1) % 2 == 1) ? (32'hA000_0000 + 32'(i - 1)) : (32'h100 + 32'(i - 1));
        checks++;
        if (out_valid !== 1'b1 || out_wb_value !== exp_val || out_dest !== 4'(i - 1) || out_count !== 2'd1) begin
          errors++;
          $display("FAIL stream_%0d: got v=%0b val=%h dest=%0d cnt=%0d want 1/%h/%0d/1",
                   i - 1, out_valid, out_wb_value, out_dest, out_count, exp_val, i - 1);
        end
        $display("txn stream beat %0d wb_value=%h", i - 1, out_wb_value);
      end
      if (i < 8) set_beat(1'b1, 1'(i % 2), 32'h100 + 32'(i), 32'hA000_0000 + 32'(i), 4'(i));
      else in_valid = 1'b0;
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got %0b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    set_beat(1'b1, 1'b1, 32'h77, 32'h88, 4'd6);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_held: got %0b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %0b want 0", out_valid); end
    checks++; if (out_wb_en !== 1'b0) begin errors++; $display("FAIL arst_wb_en: got %0b want 0", out_wb_en); end
    checks++; if (out_count !== 2'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", out_count); end
    checks++; if (out_wb_value !== 32'h0 || out_dest !== 4'h0 || out_mem_read !== 1'b0) begin
      errors++; $display("FAIL arst_payload: got val=%h dest=%h mr=%0b want 0", out_wb_value, out_dest, out_mem_read);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL arst_after: got rdy=%0b v=%0b want 1/0", in_ready, out_valid); end
    $display("txn async reset");
  endtask

  initial begin
    test_reset();
    test_alu_beat();
    test_mem_beat();
`ifdef WB_PIPE_SKID_EN
    test_skid_stall();
`else
    test_single_stall();
`endif
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, limit 100000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
